seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment display driver. Samples the scanned `seg`/`an` lines and decodes each active-low segment pattern back to a BCD digit. Assembles the four scanned digits into a 16-bit mm:ss BCD word and, optionally, the seconds count. Sits beside the display path as a loop-back monitor for self-test and for closed-loop simulation of the egg-timer display.

---
 rtl/seg7_scan_decoder_if.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 132 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Scanned 7-segment bus plus the decoded frame outputs of seg7_scan_decoder.
// count/count_valid exist only when SEG_TO_COUNT_EN is defined.
interface seg7_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        frame_valid;
    logic        seg_err;
`ifdef SEG_TO_COUNT_EN
    logic [11:0] count;
    logic        count_valid;
`endif

`ifdef SEG_TO_COUNT_EN
    modport master (output seg, an, input bcd, frame_valid, seg_err, count, count_valid);
    modport slave  (input seg, an, output bcd, frame_valid, seg_err, count, count_valid);
`else
    modport master (output seg, an, input bcd, frame_valid, seg_err);
    modport slave  (input seg, an, output bcd, frame_valid, seg_err);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Loop-back monitor: decodes scanned active-low seg/an lines into an mm:ss BCD frame.
// Optional SEG_TO_COUNT_EN adds the m*60+s count output and a minutes/seconds-tens range check.
module seg7_scan_decoder #(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_decoder_if.slave bus
);
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [6:0]  s_seg;
    logic [3:0]  s_an;
    logic [3:0]  stab;
    logic        cap_done;
    logic [3:0]  got;
    logic [15:0] slots;

    logic        same_pair;
    logic        an_blank;
    logic        an_onehot;
    logic        stable;
    logic        dig_legal;
    logic [3:0]  dig_val;
    logic [1:0]  idx;
    logic        cap_ok;
    logic        in_err;
    logic        frame_done;
    logic        range_err;
    logic [3:0]  got_next;

    assign same_pair  = (bus.an == s_an) && (bus.seg == s_seg);
    assign an_blank   = (s_an == 4'b1111);
    assign an_onehot  = (s_an == 4'b0111) || (s_an == 4'b1011) ||
                        (s_an == 4'b1101) || (s_an == 4'b1110);
    assign stable     = (stab == SETTLE_C);
    assign frame_done = (got == 4'b1111);

    always_comb begin
        dig_legal = 1'b1;
        dig_val   = 4'd0;
        case (s_seg)
            7'b1000000: dig_val = 4'd0;
            7'b1111001: dig_val = 4'd1;
            7'b0100100: dig_val = 4'd2;
            7'b0110000: dig_val = 4'd3;
            7'b0011001: dig_val = 4'd4;
            7'b0010010: dig_val = 4'd5;
            7'b0000010: dig_val = 4'd6;
            7'b1111000: dig_val = 4'd7;
            7'b0000000: dig_val = 4'd8;
            7'b0010000: dig_val = 4'd9;
            default:    dig_legal = 1'b0;
        endcase
    end

    always_comb begin
        idx = 2'd0;
        case (s_an)
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

    // A phase is acted on once; an illegal anode does not wait for the settle count.
    assign cap_ok = stable && an_onehot && !cap_done && dig_legal;
    assign in_err = (!cap_done && !an_blank && !an_onehot) ||
                    (stable && an_onehot && !cap_done && !dig_legal);

`ifdef SEG_TO_COUNT_EN
    assign range_err = (slots[15:12] > 4'd5) || (slots[7:4] > 4'd5);
`else
    assign range_err = 1'b0;
`endif

    // Completion clears got first so a same-edge capture lands in the new frame.
    always_comb begin
        got_next = frame_done ? 4'b0000 : got;
        if (cap_ok)
            got_next[idx] = 1'b1;
        if (in_err)
            got_next = 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg           <= 7'b1111111;
            s_an            <= 4'b1111;
            stab            <= 4'd0;
            cap_done        <= 1'b0;
            got             <= 4'b0000;
            slots           <= 16'h0000;
            bus.bcd         <= 16'h0000;
            bus.frame_valid <= 1'b0;
            bus.seg_err     <= 1'b0;
        end else begin
            s_seg <= bus.seg;
            s_an  <= bus.an;
            if (same_pair)
                stab <= (stab >= SETTLE_C) ? SETTLE_C : stab + 4'd1;
            else
                stab <= 4'd1;
            if (bus.an != s_an)
                cap_done <= 1'b0;
            else if (cap_ok || in_err)
                cap_done <= 1'b1;
            if (cap_ok)
                slots[idx*4 +: 4] <= dig_val;
            got             <= got_next;
            bus.frame_valid <= frame_done && !range_err;
            bus.seg_err     <= in_err || (frame_done && range_err);
            if (frame_done && !range_err)
                bus.bcd <= slots;
        end
    end

`ifdef SEG_TO_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.count       <= 12'd0;
            bus.count_valid <= 1'b0;
        end else begin
            bus.count_valid <= bus.frame_valid;
            if (bus.frame_valid)
                bus.count <= 12'(bus.bcd[15:12]) * 12'd600 + 12'(bus.bcd[11:8]) * 12'd60 +
                             12'(bus.bcd[7:4]) * 12'd10 + 12'(bus.bcd[3:0]);
        end
    end
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: one instance with SETTLE=1 and one with SETTLE=3.
module tb_seg7_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fv1 = 0, err1 = 0, fv3 = 0, err3 = 0;

    seg7_scan_decoder_if bus1 ();
    seg7_scan_decoder_if bus3 ();

    seg7_scan_decoder #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seg7_scan_decoder #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus1.frame_valid) fv1++;
        if (bus1.seg_err)     err1++;
        if (bus3.frame_valid) fv3++;
        if (bus3.seg_err)     err3++;
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Called at posedge+1; leaves the pins for n edges and returns at posedge+1.
    task automatic put1(input logic [3:0] a, input logic [6:0] s, input int n);
        bus1.an = a; bus1.seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put3(input logic [3:0] a, input logic [6:0] s, input int n);
        bus3.an = a; bus3.seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan1(input int m1, input int m0, input int s1, input int s0);
        put1(4'b0111, enc(m1), 1);
        put1(4'b1011, enc(m0), 1);
        put1(4'b1101, enc(s1), 1);
        put1(4'b1110, enc(s0), 1);
    endtask

    task automatic scan3(input int m1, input int m0, input int s1, input int s0, input int hold);
        put3(4'b0111, enc(m1), hold);
        put3(4'b1011, enc(m0), hold);
        put3(4'b1101, enc(s1), hold);
        put3(4'b1110, enc(s0), hold);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus1.bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0000", bus1.bcd); end
        n_checks++;
        if (bus1.frame_valid !== 1'b0 || bus1.seg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: fv=%b err=%b expected 0 0", bus1.frame_valid, bus1.seg_err);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count !== 12'd0 || bus1.count_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_count: got %0d/%b expected 0/0", bus1.count, bus1.count_valid);
        end
`endif
    endtask

    task automatic test_first_frame();
        scan1(0, 0, 0, 0);
        put1(4'b1111, 7'h7f, 1);
        n_checks++;
        if (bus1.frame_valid !== 1'b0) begin n_fail++; $display("FAIL early_fv: got %b expected 0", bus1.frame_valid); end
        put1(4'b1111, 7'h7f, 1);
        n_checks++;
        if (bus1.frame_valid !== 1'b1) begin n_fail++; $display("FAIL first_fv: got %b expected 1", bus1.frame_valid); end
        n_checks++;
        if (bus1.bcd !== 16'h0000) begin n_fail++; $display("FAIL first_bcd: got %h expected 0000", bus1.bcd); end
        put1(4'b1111, 7'h7f, 1);
        n_checks++;
        if (bus1.frame_valid !== 1'b0) begin n_fail++; $display("FAIL fv_one_cycle: got %b expected 0", bus1.frame_valid); end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count_valid !== 1'b1 || bus1.count !== 12'd0) begin
            n_fail++; $display("FAIL first_count: got %0d/%b expected 0/1", bus1.count, bus1.count_valid);
        end
`endif
        put1(4'b1111, 7'h7f, 2);
    endtask

    task automatic test_frames();
        int f0;
        f0 = fv1;
        scan1(0, 5, 4, 5);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (bus1.bcd !== 16'h0545 || fv1 - f0 !== 1) begin
            n_fail++; $display("FAIL frame_0545: got %h/%0d expected 0545/1", bus1.bcd, fv1 - f0);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count !== 12'd345) begin n_fail++; $display("FAIL count_345: got %0d expected 345", bus1.count); end
`endif
        f0 = fv1;
        scan1(5, 9, 5, 9);
        scan1(5, 9, 5, 9);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (bus1.bcd !== 16'h5959 || fv1 - f0 !== 2) begin
            n_fail++; $display("FAIL frame_5959: got %h/%0d expected 5959/2", bus1.bcd, fv1 - f0);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count !== 12'd3599) begin n_fail++; $display("FAIL count_3599: got %0d expected 3599", bus1.count); end
`endif
    endtask

    task automatic test_bad_pattern();
        int f0, e0;
        f0 = fv1; e0 = err1;
        put1(4'b0111, enc(1), 1);
        put1(4'b1011, enc(2), 1);
        put1(4'b1101, 7'b1111111, 1);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (err1 - e0 !== 1 || fv1 - f0 !== 0 || bus1.bcd !== 16'h5959) begin
            n_fail++; $display("FAIL bad_pattern: err=%0d fv=%0d bcd=%h expected 1 0 5959", err1 - e0, fv1 - f0, bus1.bcd);
        end
        f0 = fv1;
        scan1(1, 2, 3, 4);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (bus1.bcd !== 16'h1234 || fv1 - f0 !== 1) begin
            n_fail++; $display("FAIL after_bad_pattern: got %h/%0d expected 1234/1", bus1.bcd, fv1 - f0);
        end
    endtask

    task automatic test_bad_anode();
        int f0, e0;
        f0 = fv1; e0 = err1;
        put1(4'b0111, enc(4), 1);
        put1(4'b1001, enc(3), 1);
        put1(4'b1111, 7'h7f, 3);
        n_checks++;
        if (err1 - e0 !== 1 || fv1 - f0 !== 0) begin
            n_fail++; $display("FAIL bad_anode: err=%0d fv=%0d expected 1 0", err1 - e0, fv1 - f0);
        end
        e0 = err1;
        put1(4'b0111, enc(2), 1);
        put1(4'b1011, enc(1), 1);
        put1(4'b1111, 7'h7f, 3);
        put1(4'b1101, enc(0), 1);
        put1(4'b1110, enc(9), 1);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (err1 - e0 !== 0 || bus1.bcd !== 16'h2109 || fv1 - f0 !== 1) begin
            n_fail++; $display("FAIL blank_gap: err=%0d bcd=%h fv=%0d expected 0 2109 1", err1 - e0, bus1.bcd, fv1 - f0);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count !== 12'd1269) begin n_fail++; $display("FAIL count_1269: got %0d expected 1269", bus1.count); end
`endif
    endtask

    task automatic test_settle();
        int f0, e0;
        f0 = fv3; e0 = err3;
        scan3(8, 0, 4, 7, 2);
        put3(4'b1111, 7'h7f, 6);
        n_checks++;
        if (fv3 - f0 !== 0 || err3 - e0 !== 0 || bus3.bcd !== 16'h0000) begin
            n_fail++; $display("FAIL settle_short: fv=%0d err=%0d bcd=%h expected 0 0 0000", fv3 - f0, err3 - e0, bus3.bcd);
        end
        scan3(0, 8, 4, 7, 3);
        put3(4'b1111, 7'h7f, 8);
        n_checks++;
        if (fv3 - f0 !== 1 || bus3.bcd !== 16'h0847) begin
            n_fail++; $display("FAIL settle_ok: fv=%0d bcd=%h expected 1 0847", fv3 - f0, bus3.bcd);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus3.count !== 12'd527) begin n_fail++; $display("FAIL count_527: got %0d expected 527", bus3.count); end
`endif
    endtask

    task automatic test_mid_reset();
        int f0, e0;
        put1(4'b0111, enc(7), 1);
        put1(4'b1011, enc(7), 1);
        put1(4'b1101, enc(7), 1);
        put1(4'b1111, 7'h7f, 1);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus1.bcd !== 16'h0000 || bus1.frame_valid !== 1'b0 || bus1.seg_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: bcd=%h fv=%b err=%b expected 0000 0 0", bus1.bcd, bus1.frame_valid, bus1.seg_err);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count !== 12'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", bus1.count); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        f0 = fv1; e0 = err1;
        put1(4'b1110, enc(7), 1);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (fv1 - f0 !== 0) begin n_fail++; $display("FAIL got_cleared: fv=%0d expected 0", fv1 - f0); end
        put1(4'b0011, enc(1), 1);
        put1(4'b1111, 7'h7f, 2);
        scan1(2, 3, 1, 7);
        put1(4'b1111, 7'h7f, 4);
        n_checks++;
        if (bus1.bcd !== 16'h2317 || fv1 - f0 !== 1 || err1 - e0 !== 1) begin
            n_fail++; $display("FAIL frame_2317: bcd=%h fv=%0d err=%0d expected 2317 1 1", bus1.bcd, fv1 - f0, err1 - e0);
        end
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.count !== 12'd1397) begin n_fail++; $display("FAIL count_1397: got %0d expected 1397", bus1.count); end
`endif
        f0 = fv1; e0 = err1;
        scan1(6, 3, 0, 0);
        put1(4'b1111, 7'h7f, 4);
`ifdef SEG_TO_COUNT_EN
        n_checks++;
        if (bus1.bcd !== 16'h2317 || fv1 - f0 !== 0 || err1 - e0 !== 1) begin
            n_fail++; $display("FAIL range_6300: bcd=%h fv=%0d err=%0d expected 2317 0 1", bus1.bcd, fv1 - f0, err1 - e0);
        end
`else
        n_checks++;
        if (bus1.bcd !== 16'h6300 || fv1 - f0 !== 1 || err1 - e0 !== 0) begin
            n_fail++; $display("FAIL frame_6300: bcd=%h fv=%0d err=%0d expected 6300 1 0", bus1.bcd, fv1 - f0, err1 - e0);
        end
`endif
    endtask

    initial begin
        bus1.an = 4'b1111; bus1.seg = 7'h7f;
        bus3.an = 4'b1111; bus3.seg = 7'h7f;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        put1(4'b1111, 7'h7f, 2);
        test_first_frame();
        test_frames();
        test_bad_pattern();
        test_bad_anode();
        test_settle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
